// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexer for a common-anode display: per-frame snapshot,
// dead time at the start of each digit slot and optional leading-zero blanking.
module seven_segment_scanner #(
  parameter int         REFRESH_DIV  = 50000,
  parameter int         DEAD_CYCLES  = 2,
  parameter logic [6:0] ZERO_PATTERN = 7'b1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] u_segment,
  input  logic [6:0] d_segment,
  input  logic [6:0] h_segment,
  input  logic [6:0] t_segment,
  input  logic       blank_lz,
  input  logic       enable,
  output logic [6:0] seg,
  output logic [3:0] an_n,
  output logic       frame_tick
);

  localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYCLES);
  localparam logic [6:0]    BLANK   = 7'h7F;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][6:0] snap_q, snap_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_n_q, an_n_d;
  logic            frame_tick_q, frame_tick_d;

  logic wrap, capture;
  logic t_blank, h_blank, d_blank;

  always_comb begin
    wrap    = (cnt_q == CNT_MAX);
    capture = wrap && (idx_q == 2'd3);
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;

    // Blanking cascades from the thousand digit downwards; the unit always shows.
    t_blank = blank_lz && (t_segment == ZERO_PATTERN);
    h_blank = t_blank && (h_segment == ZERO_PATTERN);
    d_blank = h_blank && (d_segment == ZERO_PATTERN);

    snap_d = snap_q;
    if (capture) begin
      snap_d[3] = t_blank ? BLANK : t_segment;
      snap_d[2] = h_blank ? BLANK : h_segment;
      snap_d[1] = d_blank ? BLANK : d_segment;
      snap_d[0] = u_segment;
    end
    frame_tick_d = capture;

    seg_d  = snap_q[idx_q];
    an_n_d = (!enable || (cnt_q < DEAD)) ? 4'b1111 : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_q       <= {4{BLANK}};
      seg_q        <= BLANK;
      an_n_q       <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      seg_q        <= seg_d;
      an_n_q       <= an_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an_n       = an_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexes the four 7-bit digit patterns from the unit/ten/hundred/thousand segment decoders onto one shared segment bus with per-digit enables. It sits directly downstream of the four-digit segment conversion stage and drives the board pins of a common-anode, four-digit display. The block takes a per-frame snapshot to prevent tearing, inserts dead time between digits against ghosting, and can blank leading zeros.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot (50 MHz gives a 1 kHz digit rate and a 250 Hz frame rate); must be ≥ DEAD_CYCLES+2.
- DEAD_CYCLES, 2: cycles at the start of each slot with all digits off.
- ZERO_PATTERN, 7'b1000000: active-low gfedcba pattern of "0", used for leading-zero detection.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- u_segment  in  7  unit digit pattern, active-low gfedcba.
- d_segment  in  7  ten digit pattern.
- h_segment  in  7  hundred digit pattern.
- t_segment  in  7  thousand digit pattern.
- blank_lz  in  1  1 = blank leading zeros; sampled at capture.
- enable  in  1  0 = all digits off; scanning continues.
- seg  out  7  shared segment bus, active-low.
- an_n  out  4  digit enables, active-low; bit0 = unit … bit3 = thousand.
- frame_tick  out  1  one-cycle pulse at each snapshot capture.

## Operation
- Counter cnt runs 0..REFRESH_DIV-1 and wraps. Width is $clog2(REFRESH_DIV).
- Digit index idx (2 bits) advances 0→1→2→3→0 on each cycle where cnt == REFRESH_DIV-1.
- Capture: on the wrap where idx goes 3→0, load all four inputs into the snapshot registers snap[0..3] and pulse frame_tick (registered, high for exactly 1 cycle).
- Leading-zero blanking, applied to the captured values when blank_lz = 1:
  - thousand → 7'h7F if t_segment == ZERO_PATTERN;
  - hundred → 7'h7F if thousand was blanked and h_segment == ZERO_PATTERN;
  - ten → 7'h7F if hundred was blanked and d_segment == ZERO_PATTERN;
  - unit is never blanked.
- Output registers, updated every cycle from the current cnt, idx and snap:
  - seg ← snap[idx];
  - an_n ← 4'b1111 if enable == 0 or cnt < DEAD_CYCLES; otherwise ~(1 << idx).
- Input changes between captures have no effect on the outputs.
- enable does not stop cnt, idx or capture.

## Timing
- Reset values: cnt = 0, idx = 0, snap[0..3] = 7'h7F, seg = 7'h7F, an_n = 4'b1111, frame_tick = 0.
- seg and an_n lag the (cnt, idx) state by 1 cycle (registered outputs).
- First capture happens 4·REFRESH_DIV cycles after reset release, so the display is blank for the first frame.
- Frame period is exactly 4·REFRESH_DIV cycles.
- Each digit is on for REFRESH_DIV-DEAD_CYCLES cycles per frame.
- frame_tick is asserted in the same cycle in which idx = 0 and cnt = 0 are first visible after the wrap.
- Only one bit of an_n is ever low, and it is never low during dead time.
- Asserting reset mid-slot forces all outputs to their reset values immediately (asynchronous), with no glitch-through of a digit.
- enable going 0 takes effect on an_n 1 cycle later. enable returning to 1 re-enables the current slot, subject to dead time.

## Test plan
1. REFRESH_DIV=4, DEAD_CYCLES=1: release reset, inputs u/d/h/t = 7'h79, 7'h24, 7'h30, 7'h19 ("1234"). Required: seg = 7'h7F and an_n = 4'b1111 until the first frame_tick at cycle 16. In the following frame, each 4-cycle slot shows 1 cycle of an_n = 1111, then 3 cycles of an_n = 1110/1101/1011/0111 with seg = 79/24/30/19 respectively.
2. blank_lz=1, inputs "0042" (t = h = ZERO_PATTERN, d = 7'h19, u = 7'h24). Required: slots 3 and 2 show seg = 7'h7F; slots 1 and 0 show 19 and 24. Then inputs "0000": only the unit shows 7'h40.
3. Change the inputs mid-frame. Required: seg keeps the old values until the next frame_tick and switches exactly in the slot-0 output after it.
4. Drop enable low for 10 cycles mid-slot. Required: an_n = 4'b1111 for 10 cycles starting 1 cycle later, and frame_tick spacing stays at 16 cycles.
5. Assert rst_n low mid-slot 2, asynchronously between edges. Required: an_n = 4'b1111 and seg = 7'h7F immediately. After release, the sequence restarts exactly as in scenario 1.
6. Over 1000 frames with random inputs, check continuously: an_n is never low on more than one bit, and frame_tick spacing is always 4·REFRESH_DIV cycles.
